mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences the data-memory port behind the EX/MEM pipeline register and shares that port between the pipeline MEM stage and an external loader/debug requester.
- Drives a registered req/ack memory handshake with variable latency and a timeout.
- Stalls the pipeline while a MEM-stage access is outstanding.
- Returns read data to MEM/WB and to the external port.

Parameters:
TIMEOUT, 16, max cycles in a WAIT state without mem_ack before the access is aborted (>=2)
MAX_STREAK, 4, max consecutive CPU grants while ext_req is pending before the external requester is forced a grant (>=1)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
EX_MEM_MemRead  in  1  MEM-stage load
EX_MEM_MemWrite  in  1  MEM-stage store
EX_MEM_ALUout  in  32  MEM-stage address
EX_MEM_RegReadData2  in  32  MEM-stage store data
ext_req  in  1  external access request, held until ext_ack
ext_we  in  1  external write
ext_addr  in  32  external address
ext_wdata  in  32  external write data
mem_ack  in  1  memory completes the access this cycle
mem_rdata  in  32  memory read data, valid with mem_ack
mem_req  out  1  registered memory request
mem_we  out  1  registered write enable
mem_addr  out  32  registered address
mem_wdata  out  32  registered write data
stall  out  1  combinational; freezes PC/IF_ID/ID_EX/EX_MEM, bubbles MEM/WB
cpu_rdata  out  32  load data to MEM/WB, valid while state==CPU_DONE
ext_ack  out  1  one-cycle completion pulse to external requester
ext_rdata  out  32  external read data, valid with ext_ack
timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset (async): state=IDLE; mem_req/mem_we/ext_ack/timeout_err=0; mem_addr/mem_wdata/cpu_rdata/ext_rdata=0; wait and streak counters=0.
- cpu_acc = EX_MEM_MemRead | EX_MEM_MemWrite. Both set is treated as a write.
- States: IDLE, CPU_WAIT, CPU_DONE, EXT_WAIT, EXT_DONE.
- IDLE grant rule:
  - CPU wins if cpu_acc and (!ext_req or streak<MAX_STREAK).
  - Otherwise EXT wins if ext_req.
- IDLE, CPU granted -> CPU_WAIT. Next edge loads mem_req=1, mem_we=EX_MEM_MemWrite, mem_addr=ALUout, mem_wdata=RegReadData2. streak increments if ext_req, else clears to 0.
- IDLE, EXT granted -> EXT_WAIT. Request is loaded from the ext_* inputs; streak clears to 0.
- WAIT states:
  - Wait counter increments each cycle.
  - On mem_ack: mem_req drops at the next edge; rdata is latched into cpu_rdata or ext_rdata; go to the matching DONE state.
  - If the counter reaches TIMEOUT-1 without mem_ack: mem_req drops; rdata is forced to ERR_DATA; timeout_err is set; go to the matching DONE state.
- mem_ack outside a WAIT state is ignored.
- CPU_DONE: lasts 1 cycle, then IDLE.
- EXT_DONE: ext_ack=1 for 1 cycle, then IDLE. ext_req may drop in that cycle.
- stall = cpu_acc & (state != CPU_DONE). This covers a CPU access waiting behind an external transfer. In CPU_DONE stall=0, so the pipeline advances and the next MEM-stage instruction appears.
- Minimum CPU access with immediate ack: 3 cycles (IDLE, CPU_WAIT, CPU_DONE), i.e. 2 stall cycles.
- Back-to-back CPU accesses return to IDLE between them. An EXT grant can slot in there only per the streak rule.
- EX_MEM inputs are held stable by stall. The block does not re-sample them after the grant.
- Reset mid-transfer aborts immediately: mem_req=0, stall follows cpu_acc. No ext_ack is issued for the aborted transfer.

Test Plan:
- CPU load, memory acks 1 cycle after mem_req, addr 0x10, rdata 0x12345678 -> mem_req high 1 cycle with mem_we=0; stall high 2 cycles; cpu_rdata=0x12345678 in CPU_DONE with stall=0.
- CPU store, addr 0x20, data 0xA5A5A5A5, ack after 5 cycles -> mem_we=1 and wdata held for all 5 cycles; stall high 6 cycles; no ext_ack.
- ext_req held continuously with back-to-back CPU loads, MAX_STREAK=4 -> exactly 4 CPU grants, then 1 EXT grant while stall stays high; ext_ack pulses once; streak resumes from 0.
- mem_ack never asserted for a CPU load, TIMEOUT=16 -> mem_req drops after 16 cycles; cpu_rdata=0xDEADBEEF; timeout_err=1 and stays set until reset.
- Simultaneous ext_req and cpu_acc from IDLE with streak=0 -> CPU granted first; EXT served after CPU_DONE if no new CPU access, ext_rdata correct.
- reset asserted during CPU_WAIT with mem_req=1 -> mem_req=0 and state=IDLE in the same cycle without a clock edge; timeout_err=0; no ext_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences the data-memory port behind the EX/MEM register and shares it
//   between the pipeline MEM stage and an external loader/debug requester.
//   Memory side is a registered req/ack handshake with variable latency and
//   a per-access timeout; the pipeline is stalled while a MEM-stage access
//   is outstanding.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   EX_MEM_MemRead/MemWrite     MEM-stage load/store (both set = store)
//   EX_MEM_ALUout               MEM-stage address
//   EX_MEM_RegReadData2         MEM-stage store data
//   ext_req/ext_we/ext_addr/ext_wdata   external request, held until ext_ack
//   mem_ack, mem_rdata          memory completion and read data
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   stall                       freezes front of pipe, bubbles MEM/WB
//   cpu_rdata                   load data, valid while in CPU_DONE
//   ext_ack, ext_rdata          one-cycle external completion and data
//   timeout_err                 sticky timeout flag
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MAX_STREAK = 4,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [31:0] EX_MEM_ALUout,
    input  logic [31:0] EX_MEM_RegReadData2,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] cpu_rdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        timeout_err
);

    localparam int unsigned WW = $clog2(TIMEOUT);
    localparam int unsigned SW = $clog2(MAX_STREAK + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        CPU_WAIT,
        CPU_DONE,
        EXT_WAIT,
        EXT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q;
    logic [SW-1:0] streak_q;

    logic cpu_acc;
    logic grant_cpu, grant_ext;
    logic acked, expired;

    assign cpu_acc = EX_MEM_MemRead | EX_MEM_MemWrite;
    // A CPU access queued behind an external transfer also stalls.
    assign stall   = cpu_acc & (state_q != CPU_DONE);

    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        acked     = 1'b0;
        expired   = 1'b0;
        case (state_q)
            IDLE: begin
                // CPU has priority until it has won MAX_STREAK times in a
                // row over a waiting external requester.
                if (cpu_acc && (!ext_req || (streak_q < STREAK_MAX))) begin
                    grant_cpu = 1'b1;
                    state_d   = CPU_WAIT;
                end else if (ext_req) begin
                    grant_ext = 1'b1;
                    state_d   = EXT_WAIT;
                end
            end
            CPU_WAIT, EXT_WAIT: begin
                if (mem_ack) begin
                    acked = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    expired = 1'b1;
                end
                if (mem_ack || (wait_q == WAIT_LAST)) begin
                    state_d = (state_q == CPU_WAIT) ? CPU_DONE : EXT_DONE;
                end
            end
            CPU_DONE: state_d = IDLE;
            EXT_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata   <= '0;
            ext_rdata   <= '0;
            ext_ack     <= 1'b0;
            timeout_err <= 1'b0;
            wait_q      <= '0;
            streak_q    <= '0;
        end else begin
            ext_ack <= (state_d == EXT_DONE);

            if (grant_cpu) begin
                mem_req   <= 1'b1;
                mem_we    <= EX_MEM_MemWrite;
                mem_addr  <= EX_MEM_ALUout;
                mem_wdata <= EX_MEM_RegReadData2;
                streak_q  <= ext_req ? streak_q + 1'b1 : '0;
            end else if (grant_ext) begin
                mem_req   <= 1'b1;
                mem_we    <= ext_we;
                mem_addr  <= ext_addr;
                mem_wdata <= ext_wdata;
                streak_q  <= '0;
            end

            if ((state_q == CPU_WAIT) || (state_q == EXT_WAIT)) begin
                if (acked || expired) begin
                    mem_req <= 1'b0;
                    wait_q  <= '0;
                    if (state_q == CPU_WAIT) begin
                        cpu_rdata <= acked ? mem_rdata : ERR_DATA;
                    end else begin
                        ext_rdata <= acked ? mem_rdata : ERR_DATA;
                    end
                    if (expired) begin
                        timeout_err <= 1'b1;
                    end
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
            end
        end
    end

endmodule
